// File: rtl/uart_cmd_parser_if.sv
// Byte-stream input and command/error outputs of the UART command parser.
// The master side feeds receiver bytes in; the slave side is the parser.
interface uart_cmd_parser_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  cmd_code;
  logic [15:0] cmd_arg;
  logic        cmd_valid;
  logic        cmd_err;
  logic [1:0]  err_code;
  logic        busy;

  modport master (
    output rx_data, rx_valid,
    input  cmd_code, cmd_arg, cmd_valid, cmd_err, err_code, busy
  );

  modport slave (
    input  rx_data, rx_valid,
    output cmd_code, cmd_arg, cmd_valid, cmd_err, err_code, busy
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Assembles "$<letter><0..MAX_DIGITS digits><CR|LF>" frames from the UART byte
// stream into command/argument pairs; rejects malformed or stalled frames.
module uart_cmd_parser #(
  parameter int CLK_FREQ   = 1_000_000,
  parameter int TIMEOUT_MS = 100,
  parameter int MAX_DIGITS = 5
) (
  input logic            clk,
  input logic            reset,
  uart_cmd_parser_if.slave bus
);
  localparam int TIMEOUT_CYCLES = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam int DW = $clog2(MAX_DIGITS + 1);

  localparam logic [1:0] E_BAD_CMD  = 2'd0;
  localparam logic [1:0] E_BAD_CHAR = 2'd1;
  localparam logic [1:0] E_OVERFLOW = 2'd2;
  localparam logic [1:0] E_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {IDLE, CMD, ARG} state_t;

  state_t        state_q, state_d;
  logic [7:0]    pend_q, pend_d;
  logic [15:0]   acc_q, acc_d;
  logic [DW-1:0] ndig_q, ndig_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    code_q, code_d;
  logic [15:0]   arg_q, arg_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;
  logic [1:0]    ecode_q, ecode_d;

  logic [7:0]  rx;
  logic        rv;
  logic        is_dollar, is_upper, is_lower, is_letter, is_digit, is_eol;
  logic        tmo, ovf;
  logic [19:0] prod;

  assign rx        = bus.rx_data;
  assign rv        = bus.rx_valid;
  assign is_dollar = (rx == 8'h24);
  assign is_upper  = (rx >= 8'h41) && (rx <= 8'h5A);
  assign is_lower  = (rx >= 8'h61) && (rx <= 8'h7A);
  assign is_letter = is_upper || is_lower;
  assign is_digit  = (rx >= 8'h30) && (rx <= 8'h39);
  assign is_eol    = (rx == 8'h0D) || (rx == 8'h0A);

  // Expiry fires on the edge where the idle count would reach TIMEOUT_CYCLES-1;
  // a byte in that same cycle takes priority because every use is gated by !rv.
  assign tmo  = (cnt_q == CW'(TIMEOUT_CYCLES - 2));
  assign prod = {4'd0, acc_q} * 20'd10 + {16'd0, rx[3:0]};
  assign ovf  = (ndig_q == DW'(MAX_DIGITS)) || (prod > 20'd65535);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and frame datapath
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    acc_d   = acc_q;
    ndig_d  = ndig_q;
    cnt_d   = (state_q == IDLE || rv || tmo) ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE: if (rv && is_dollar) state_d = CMD;
      CMD: begin
        if (rv) begin
          if (is_letter) begin
            state_d = ARG;
            pend_d  = is_upper ? rx : rx - 8'h20;
            acc_d   = '0;
            ndig_d  = '0;
          end else if (!is_dollar) begin
            state_d = IDLE;
          end
        end else if (tmo) begin
          state_d = IDLE;
        end
      end
      ARG: begin
        if (rv) begin
          if (is_digit) begin
            if (ovf) state_d = IDLE;
            else begin
              acc_d  = prod[15:0];
              ndig_d = ndig_q + 1'b1;
            end
          end else if (is_dollar) begin
            state_d = CMD;
          end else begin
            state_d = IDLE;
          end
        end else if (tmo) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: pulses and the visible command/error registers
  always_comb begin
    vld_d   = 1'b0;
    err_d   = 1'b0;
    ecode_d = ecode_q;
    code_d  = code_q;
    arg_d   = arg_q;
    case (state_q)
      CMD: begin
        if (rv) begin
          if (!is_letter && !is_dollar) begin
            err_d   = 1'b1;
            ecode_d = E_BAD_CMD;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          ecode_d = E_TIMEOUT;
        end
      end
      ARG: begin
        if (rv) begin
          if (is_digit) begin
            if (ovf) begin
              err_d   = 1'b1;
              ecode_d = E_OVERFLOW;
            end
          end else if (is_eol) begin
            vld_d  = 1'b1;
            code_d = pend_q;
            arg_d  = acc_q;
          end else if (!is_dollar) begin
            err_d   = 1'b1;
            ecode_d = E_BAD_CHAR;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          ecode_d = E_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q  <= '0;
      acc_q   <= '0;
      ndig_q  <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      arg_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      ecode_q <= '0;
    end else begin
      pend_q  <= pend_d;
      acc_q   <= acc_d;
      ndig_q  <= ndig_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      arg_q   <= arg_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      ecode_q <= ecode_d;
    end
  end

  assign bus.cmd_code  = code_q;
  assign bus.cmd_arg   = arg_q;
  assign bus.cmd_valid = vld_q;
  assign bus.cmd_err   = err_q;
  assign bus.err_code  = ecode_q;
  assign bus.busy      = (state_q != IDLE);
endmodule
